// File: rtl/serial_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : serial_window_scheduler
// Brief    : Steps a serial engine over an OUT_W x OUT_H grid of window
//            addresses and buffers one result per window.
// Revision : 1.0 - initial release
// ============================================================================
module serial_window_scheduler #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int OUT_W      = 2,
    parameter int OUT_H      = 2,
    parameter int ROW_STRIDE = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_i,
    input  logic [ADDR_W-1:0]                base_addr_i,
    output logic                             en_o,
    output logic [ADDR_W-1:0]                feature_baseaddr_o,
    input  logic                             is_done_i,
    input  logic [DATA_W-1:0]                out_i,
    output logic                             busy_o,
    output logic                             done_o,
    input  logic [$clog2(OUT_W*OUT_H)-1:0]   rd_idx_i,
    output logic [DATA_W-1:0]                rd_data_o
);

    localparam int c_N     = OUT_W * OUT_H;
    localparam int c_IDX_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int c_ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_done_q;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_base;
    logic [c_ROW_W-1:0]  r_row;
    logic [c_COL_W-1:0]  r_col;
    logic [c_IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0]   r_buf [c_N];
    logic [ADDR_W-1:0]   w_row_off;
    logic                w_accept;
    logic                w_complete;
    logic                w_last;

    // A completion is a fresh rise; a level already high on entry to RUN is ignored.
    assign w_accept   = (r_state == S_IDLE) && start_i;
    assign w_complete = (r_state == S_RUN) && is_done_i && !r_done_q;
    assign w_last     = (r_idx == c_LAST_IDX);
    assign w_row_off  = ADDR_W'((int'(r_row) + 1) * ROW_STRIDE);

    assign feature_baseaddr_o = r_addr;
    assign rd_data_o          = r_buf[rd_idx_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        en_o         = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                en_o   = 1'b1;
                busy_o = 1'b1;
                if (w_complete && w_last) begin
                    w_state_next = S_FIN;
                end
            end
            S_FIN: begin
                done_o       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q <= 1'b0;
            r_addr   <= '0;
            r_base   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_idx    <= '0;
        end else begin
            r_done_q <= is_done_i;
            if (w_accept) begin
                r_addr <= base_addr_i;
                r_base <= base_addr_i;
                r_row  <= '0;
                r_col  <= '0;
                r_idx  <= '0;
            end else if (w_complete && !w_last) begin
                r_idx <= r_idx + 1'b1;
                // Row wrap jumps to the next row start rather than continuing linearly.
                if (r_col == c_LAST_COL) begin
                    r_col  <= '0;
                    r_row  <= r_row + 1'b1;
                    r_addr <= r_base + w_row_off;
                end else begin
                    r_col  <= r_col + 1'b1;
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_N; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_complete) begin
            r_buf[r_idx] <= out_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_window_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_window_scheduler
// Brief    : Directed self-checking bench for serial_window_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_window_scheduler;

    logic       clk;
    logic       rst;
    logic       start_i;
    logic [7:0] base_addr_i;
    logic       en_o;
    logic [7:0] feature_baseaddr_o;
    logic       is_done_i;
    logic [7:0] out_i;
    logic       busy_o;
    logic       done_o;
    logic [1:0] rd_idx_i;
    logic [7:0] rd_data_o;

    int         pass_cnt;
    int         check_cnt;
    int         done_pulses;
    logic [7:0] obs_addr [4];
    logic [7:0] obs_buf  [4];

    serial_window_scheduler dut (
        .clk                (clk),
        .rst                (rst),
        .start_i            (start_i),
        .base_addr_i        (base_addr_i),
        .en_o               (en_o),
        .feature_baseaddr_o (feature_baseaddr_o),
        .is_done_i          (is_done_i),
        .out_i              (out_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .rd_idx_i           (rd_idx_i),
        .rd_data_o          (rd_data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done_o === 1'b1) done_pulses++;
    end

    task automatic start_job(input logic [7:0] b);
        base_addr_i = b;
        start_i     = 1'b1;
        @(negedge clk);
        start_i     = 1'b0;
    endtask

    // Stub engine: result is twice the window address, done rises ~10 cycles in.
    task automatic serve(input int k, input int hold, input bit restart);
        obs_addr[k] = feature_baseaddr_o;
        repeat (4) @(negedge clk);
        if (restart) begin
            base_addr_i = 8'h55;
            start_i     = 1'b1;
            @(negedge clk);
            start_i     = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
        is_done_i = 1'b1;
        out_i     = {feature_baseaddr_o[6:0], 1'b0};
        repeat (hold) @(negedge clk);
        is_done_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_job(input logic [7:0] b, input int hold, input bit restart);
        start_job(b);
        for (int k = 0; k < 4; k++) serve(k, hold, restart);
        repeat (3) @(negedge clk);
    endtask

    task automatic read_buf();
        for (int i = 0; i < 4; i++) begin
            rd_idx_i   = 2'(i);
            #1;
            obs_buf[i] = rd_data_o;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_cnt++;
        if ({en_o, busy_o, done_o} !== 3'b000) $display("FAIL reset_ctrl: got %b expected 000", {en_o, busy_o, done_o});
        else pass_cnt++;
        check_cnt++;
        if (feature_baseaddr_o !== 8'h00) $display("FAIL reset_addr: got %0h expected 0", feature_baseaddr_o);
        else pass_cnt++;
        rst = 1'b0;
        read_buf();
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (obs_buf[i] !== 8'h00) $display("FAIL reset_buf[%0d]: got %0h expected 0", i, obs_buf[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_basic();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        int d0;
        ea = '{8'd9, 8'd10, 8'd13, 8'd14};
        eb = '{8'd18, 8'd20, 8'd26, 8'd28};
        d0 = done_pulses;
        start_job(8'd9);
        check_cnt++;
        if ({en_o, busy_o} !== 2'b11) $display("FAIL basic_en_busy: got %b expected 11", {en_o, busy_o});
        else pass_cnt++;
        for (int k = 0; k < 4; k++) serve(k, 1, 1'b0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check_cnt++;
            if (obs_addr[k] !== ea[k]) $display("FAIL basic_addr[%0d]: got %0h expected %0h", k, obs_addr[k], ea[k]);
            else pass_cnt++;
        end
        read_buf();
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (obs_buf[i] !== eb[i]) $display("FAIL basic_buf[%0d]: got %0h expected %0h", i, obs_buf[i], eb[i]);
            else pass_cnt++;
        end
        check_cnt++;
        if (done_pulses - d0 !== 1) $display("FAIL basic_done_cycles: got %0d expected 1", done_pulses - d0);
        else pass_cnt++;
        check_cnt++;
        if ({en_o, busy_o} !== 2'b00) $display("FAIL basic_idle_after: got %b expected 00", {en_o, busy_o});
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        logic [7:0] ea [4];
        logic [7:0] eb [4];
        ea = '{8'hFE, 8'hFF, 8'h02, 8'h03};
        eb = '{8'hFC, 8'hFE, 8'h04, 8'h06};
        run_job(8'hFE, 1, 1'b0);
        read_buf();
        for (int k = 0; k < 4; k++) begin
            check_cnt++;
            if (obs_addr[k] !== ea[k]) $display("FAIL wrap_addr[%0d]: got %0h expected %0h", k, obs_addr[k], ea[k]);
            else pass_cnt++;
            check_cnt++;
            if (obs_buf[k] !== eb[k]) $display("FAIL wrap_buf[%0d]: got %0h expected %0h", k, obs_buf[k], eb[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_held_done();
        logic [7:0] ea [4];
        int d0;
        ea = '{8'h20, 8'h21, 8'h24, 8'h25};
        d0 = done_pulses;
        run_job(8'h20, 5, 1'b0);
        read_buf();
        for (int k = 0; k < 4; k++) begin
            check_cnt++;
            if (obs_addr[k] !== ea[k]) $display("FAIL held_addr[%0d]: got %0h expected %0h", k, obs_addr[k], ea[k]);
            else pass_cnt++;
            check_cnt++;
            if (obs_buf[k] !== {ea[k][6:0], 1'b0}) $display("FAIL held_buf[%0d]: got %0h expected %0h", k, obs_buf[k], {ea[k][6:0], 1'b0});
            else pass_cnt++;
        end
        check_cnt++;
        if (done_pulses - d0 !== 1) $display("FAIL held_done: got %0d expected 1", done_pulses - d0);
        else pass_cnt++;
    endtask

    task automatic test_restart_ignored();
        logic [7:0] ea [4];
        int d0;
        ea = '{8'd9, 8'd10, 8'd13, 8'd14};
        d0 = done_pulses;
        run_job(8'd9, 1, 1'b1);
        read_buf();
        for (int k = 0; k < 4; k++) begin
            check_cnt++;
            if (obs_addr[k] !== ea[k]) $display("FAIL restart_addr[%0d]: got %0h expected %0h", k, obs_addr[k], ea[k]);
            else pass_cnt++;
            check_cnt++;
            if (obs_buf[k] !== {ea[k][6:0], 1'b0}) $display("FAIL restart_buf[%0d]: got %0h expected %0h", k, obs_buf[k], {ea[k][6:0], 1'b0});
            else pass_cnt++;
        end
        check_cnt++;
        if (done_pulses - d0 !== 1) $display("FAIL restart_done: got %0d expected 1", done_pulses - d0);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int d0;
        d0 = done_pulses;
        start_job(8'd9);
        serve(0, 1, 1'b0);
        serve(1, 1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_cnt++;
        if ({en_o, busy_o, done_o} !== 3'b000) $display("FAIL midrst_ctrl: got %b expected 000", {en_o, busy_o, done_o});
        else pass_cnt++;
        read_buf();
        for (int i = 0; i < 4; i++) begin
            check_cnt++;
            if (obs_buf[i] !== 8'h00) $display("FAIL midrst_buf[%0d]: got %0h expected 0", i, obs_buf[i]);
            else pass_cnt++;
        end
        repeat (15) @(negedge clk);
        check_cnt++;
        if (done_pulses !== d0) $display("FAIL midrst_no_done: got %0d expected %0d", done_pulses, d0);
        else pass_cnt++;
        run_job(8'd3, 1, 1'b0);
        read_buf();
        check_cnt++;
        if (obs_addr[3] !== 8'd8 || obs_buf[3] !== 8'd16) $display("FAIL midrst_rerun: got addr %0h buf %0h expected 8 10", obs_addr[3], obs_buf[3]);
        else pass_cnt++;
        check_cnt++;
        if (done_pulses - d0 !== 1) $display("FAIL midrst_rerun_done: got %0d expected 1", done_pulses - d0);
        else pass_cnt++;
    endtask

    task automatic test_done_high_on_entry();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        is_done_i = 1'b1;
        out_i     = 8'hAA;
        @(negedge clk);
        start_job(8'h40);
        repeat (6) @(negedge clk);
        rd_idx_i = 2'd0;
        #1;
        check_cnt++;
        if (rd_data_o !== 8'h00 || feature_baseaddr_o !== 8'h40) $display("FAIL entry_no_store: got buf %0h addr %0h expected 0 40", rd_data_o, feature_baseaddr_o);
        else pass_cnt++;
        is_done_i = 1'b0;
        @(negedge clk);
        serve(0, 1, 1'b0);
        rd_idx_i = 2'd0;
        #1;
        check_cnt++;
        if (rd_data_o !== 8'h80 || feature_baseaddr_o !== 8'h41) $display("FAIL entry_fresh_rise: got buf %0h addr %0h expected 80 41", rd_data_o, feature_baseaddr_o);
        else pass_cnt++;
        for (int k = 1; k < 4; k++) serve(k, 1, 1'b0);
        repeat (3) @(negedge clk);
        read_buf();
        check_cnt++;
        if (obs_buf[3] !== 8'h8A) $display("FAIL entry_last_buf: got %0h expected 8a", obs_buf[3]);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt    = 0;
        check_cnt   = 0;
        done_pulses = 0;
        rst         = 1'b1;
        start_i     = 1'b0;
        base_addr_i = 8'h00;
        is_done_i   = 1'b0;
        out_i       = 8'h00;
        rd_idx_i    = 2'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_held_done();
        test_restart_ignored();
        test_mid_reset();
        test_done_high_on_entry();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
